icache_line_fill_ctrl: RTL and testbench
========================================

ICACHE_LINE_FILL_CTRL -- requirements
Module: icache_line_fill_ctrl

Interface
REQ-001 Parameter WB_AW, 32, address width.
REQ-002 Parameter WB_DW, 32, data width.
REQ-003 Parameter CACHELINES, 16, number of cache lines, power of 2; LW = clog2(CACHELINES).
REQ-004 Parameter CACHESIZE, 32, words per line, power of 2, at most 1023; PW = clog2(CACHESIZE), OFS = PW+2, TW = WB_AW-OFS.
REQ-005 Parameter TIMEOUT, 1023, idle-cycle limit while waiting for an ack.
REQ-006 Clock and reset: one clock mclk; reset rst_n, asynchronous, active-low.
REQ-007 mclk  in  1  clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 cpu_addr  in  WB_AW  missing CPU address; prefill_base  in  WB_AW  prefill start address.
REQ-010 refill_req, prefill_req  in  1  level requests, sampled only in IDLE.
REQ-011 cpu_dat_o  out  WB_DW  critical word; cpu_ack_o  out  1  critical-word strobe.
REQ-012 cache_busy  out  1  operation active; fill_err  out  1  sticky error flag.
REQ-013 wb_app_stb_o, wb_app_we_o  out  1; wb_app_adr_o  out  WB_AW; wb_app_sel_o  out  4; wb_app_bl_o  out  10 (burst length).
REQ-014 wb_app_dat_i  in  WB_DW; wb_app_ack_i, wb_app_lack_i, wb_app_err_i  in  1.
REQ-015 tag_cur_loc  in  LW  victim line; tag_wr, tag_uwr  out  1; tag_uptr  out  LW; tag_wdata  out  TW+1, {valid, tag}.
REQ-016 cache_mem_csb0, cache_mem_web0  out  1  active-low; cache_mem_addr0  out  LW+PW; cache_mem_wmask0  out  4; cache_mem_din0  out  WB_DW.

Function
REQ-017 States: IDLE, FILL, NEXT, DONE; an internal mode bit (REFILL/PREFILL) is latched at request acceptance.
REQ-018 IDLE: refill_req has priority over prefill_req; a prefill_req coincident with refill_req is dropped; with no request, cache_busy = 0.
REQ-019 Refill accept (next edge): busy=1, stb=1, we=0, sel=4'hF, bl=CACHESIZE, adr={cpu_addr[WB_AW-1:OFS],0}, line=tag_cur_loc, ptr=0, fill_err=0, one-cycle tag_uwr with tag_uptr=line and tag_wdata=0; state -> FILL.
REQ-020 Prefill accept: identical except adr={prefill_base[WB_AW-1:OFS],0}, line=0.
REQ-021 PREFILL mode issues one CACHESIZE-word burst per line; each burst start (accept or NEXT) pulses tag_uwr invalidating that line.
REQ-022 FILL, each ack_i cycle: next edge csb0=0, web0=0, wmask0=4'hF, addr0={line,ptr}, din0=dat_i, ptr=ptr+1 (modulo CACHESIZE); cycles without ack_i: csb0=web0=1.
REQ-023 REFILL mode: on ack_i with ptr == cpu_addr[OFS-1:2], cpu_ack_o=1 for exactly one cycle with cpu_dat_o=dat_i; otherwise cpu_ack_o=0.
REQ-024 lack_i is qualified only with ack_i; on qualified lack_i: stb=0, one-cycle tag_wr, tag_uptr=line, tag_wdata={1, burst address[WB_AW-1:OFS]}.
REQ-025 After qualified lack_i: REFILL -> DONE; PREFILL -> DONE if line == CACHELINES-1, else -> NEXT.
REQ-026 NEXT (one cycle): line=line+1, adr=adr+CACHESIZE*4, ptr=0, stb=1 -> FILL.
REQ-027 Timeout counter resets on every ack_i and at burst start, increments each FILL cycle without ack_i.
REQ-028 err_i in FILL, or counter == TIMEOUT: stb=0, fill_err=1, no tag_wr (line stays invalid), no cpu_ack_o, -> DONE; err_i outranks a simultaneous ack_i.
REQ-029 DONE (one cycle): csb0=web0=1, tag_wr=0, cpu_ack_o=0, busy=0 -> IDLE.
REQ-030 ack_i, lack_i, err_i outside FILL are ignored.

Reset
REQ-031 On reset: state IDLE, every output 0 except cache_mem_csb0=1 and cache_mem_web0=1; ptr, line, counter, mode cleared.
REQ-032 Reset mid-burst aborts immediately with no tag_wr; the interrupted line stays invalid.

Verification
REQ-033 Refill, cpu_addr=0x0000_1A4C, tag_cur_loc=5: adr=0x0000_1A00, bl=32; cpu_ack_o with 20th ack data; addr0 0xA0..0xBF; tag_wr uptr=5, wdata={1,0x34}.
REQ-034 Prefill, prefill_base=0x0000_0800: 16 bursts adr 0x800, 0x880 .. 0xF80; 16 tag_uwr and 16 tag_wr pulses, uptr 0..15; busy falls after DONE.
REQ-035 err_i on 5th ack of refill: stb drops, fill_err=1, no tag_wr, no cpu_ack_o; next refill clears fill_err.
REQ-036 No ack for TIMEOUT cycles after 3 acks: abort to DONE, fill_err=1.
REQ-037 refill_req and prefill_req same cycle: refill only, prefill dropped; requests while busy ignored.
REQ-038 rst_n low at 10th ack: all outputs at reset values asynchronously, no tag_wr.

Source files
------------

// File: rtl/icache_line_fill_ctrl.sv
// Instruction-cache line fill controller: single-line refill with critical-word
// forwarding, or a whole-cache prefill, fetched as Wishbone bursts into the data SRAM.
module icache_line_fill_ctrl #(
  parameter int WB_AW      = 32,
  parameter int WB_DW      = 32,
  parameter int CACHELINES = 16,
  parameter int CACHESIZE  = 32,
  parameter int TIMEOUT    = 1023,
  localparam int LW  = $clog2(CACHELINES),
  localparam int PW  = $clog2(CACHESIZE),
  localparam int OFS = PW + 2,
  localparam int TW  = WB_AW - OFS
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [WB_AW-1:0] cpu_addr,
  input  logic [WB_AW-1:0] prefill_base,
  input  logic             refill_req,
  input  logic             prefill_req,
  output logic [WB_DW-1:0] cpu_dat_o,
  output logic             cpu_ack_o,
  output logic             cache_busy,
  output logic             fill_err,
  output logic             wb_app_stb_o,
  output logic             wb_app_we_o,
  output logic [WB_AW-1:0] wb_app_adr_o,
  output logic [3:0]       wb_app_sel_o,
  output logic [9:0]       wb_app_bl_o,
  input  logic [WB_DW-1:0] wb_app_dat_i,
  input  logic             wb_app_ack_i,
  input  logic             wb_app_lack_i,
  input  logic             wb_app_err_i,
  input  logic [LW-1:0]    tag_cur_loc,
  output logic             tag_wr,
  output logic             tag_uwr,
  output logic [LW-1:0]    tag_uptr,
  output logic [TW:0]      tag_wdata,
  output logic             cache_mem_csb0,
  output logic             cache_mem_web0,
  output logic [LW+PW-1:0] cache_mem_addr0,
  output logic [3:0]       cache_mem_wmask0,
  output logic [WB_DW-1:0] cache_mem_din0,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // Wishbone handshake: the burst is open while wb_app_stb_o is high; each cycle
  // with wb_app_ack_i carries one beat, and wb_app_lack_i (only together with
  // wb_app_ack_i) marks the final beat. Slave strobes outside FILL are ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, NEXT = 2'd2, DONE = 2'd3} state_t;

  state_t          state;
  logic            mode_prefill;
  logic [LW-1:0]   line;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   crit_ofs;
  logic [CW-1:0]   tmo_cnt;

  assign dbg_state = state;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      mode_prefill     <= 1'b0;
      line             <= '0;
      ptr              <= '0;
      crit_ofs         <= '0;
      tmo_cnt          <= '0;
      cpu_dat_o        <= '0;
      cpu_ack_o        <= 1'b0;
      cache_busy       <= 1'b0;
      fill_err         <= 1'b0;
      wb_app_stb_o     <= 1'b0;
      wb_app_we_o      <= 1'b0;
      wb_app_adr_o     <= '0;
      wb_app_sel_o     <= '0;
      wb_app_bl_o      <= '0;
      tag_wr           <= 1'b0;
      tag_uwr          <= 1'b0;
      tag_uptr         <= '0;
      tag_wdata        <= '0;
      cache_mem_csb0   <= 1'b1;
      cache_mem_web0   <= 1'b1;
      cache_mem_addr0  <= '0;
      cache_mem_wmask0 <= '0;
      cache_mem_din0   <= '0;
    end else begin
      // Single-cycle strobes fall back to idle unless re-asserted below.
      tag_wr         <= 1'b0;
      tag_uwr        <= 1'b0;
      cpu_ack_o      <= 1'b0;
      cache_mem_csb0 <= 1'b1;
      cache_mem_web0 <= 1'b1;

      case (state)
        IDLE: begin
          if (refill_req || prefill_req) begin
            mode_prefill <= !refill_req;
            line         <= refill_req ? tag_cur_loc : '0;
            tag_uptr     <= refill_req ? tag_cur_loc : '0;
            wb_app_adr_o <= refill_req ? {cpu_addr[WB_AW-1:OFS], {OFS{1'b0}}}
                                       : {prefill_base[WB_AW-1:OFS], {OFS{1'b0}}};
            crit_ofs     <= cpu_addr[OFS-1:2];
            ptr          <= '0;
            tmo_cnt      <= '0;
            cache_busy   <= 1'b1;
            fill_err     <= 1'b0;
            wb_app_stb_o <= 1'b1;
            wb_app_we_o  <= 1'b0;
            wb_app_sel_o <= 4'hF;
            wb_app_bl_o  <= 10'(CACHESIZE);
            tag_uwr      <= 1'b1;
            tag_wdata    <= '0;
            state        <= FILL;
          end
        end

        FILL: begin
          // An error or an expired ack wait abandons the line; its tag stays invalid.
          if (wb_app_err_i || tmo_cnt == CW'(TIMEOUT)) begin
            wb_app_stb_o <= 1'b0;
            fill_err     <= 1'b1;
            state        <= DONE;
          end else if (wb_app_ack_i) begin
            cache_mem_csb0   <= 1'b0;
            cache_mem_web0   <= 1'b0;
            cache_mem_wmask0 <= 4'hF;
            cache_mem_addr0  <= {line, ptr};
            cache_mem_din0   <= wb_app_dat_i;
            ptr              <= ptr + PW'(1);
            tmo_cnt          <= '0;
            if (!mode_prefill && ptr == crit_ofs) begin
              cpu_ack_o <= 1'b1;
              cpu_dat_o <= wb_app_dat_i;
            end
            if (wb_app_lack_i) begin
              wb_app_stb_o <= 1'b0;
              tag_wr       <= 1'b1;
              tag_uptr     <= line;
              tag_wdata    <= {1'b1, wb_app_adr_o[WB_AW-1:OFS]};
              state        <= (!mode_prefill || line == LW'(CACHELINES - 1)) ? DONE : NEXT;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        NEXT: begin
          line         <= line + LW'(1);
          tag_uptr     <= line + LW'(1);
          tag_uwr      <= 1'b1;
          tag_wdata    <= '0;
          wb_app_adr_o <= wb_app_adr_o + WB_AW'(CACHESIZE * 4);
          ptr          <= '0;
          tmo_cnt      <= '0;
          wb_app_stb_o <= 1'b1;
          state        <= FILL;
        end

        default: begin
          cache_busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line_fill_ctrl.sv
// Directed bench for icache_line_fill_ctrl: refill, prefill, error, timeout,
// request priority and mid-burst reset, each checked against hand-computed values.
module tb_icache_line_fill_ctrl;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr, prefill_base;
  logic        refill_req, prefill_req;
  logic [31:0] cpu_dat_o;
  logic        cpu_ack_o, cache_busy, fill_err;
  logic        wb_app_stb_o, wb_app_we_o;
  logic [31:0] wb_app_adr_o;
  logic [3:0]  wb_app_sel_o;
  logic [9:0]  wb_app_bl_o;
  logic [31:0] wb_app_dat_i;
  logic        wb_app_ack_i, wb_app_lack_i, wb_app_err_i;
  logic [3:0]  tag_cur_loc;
  logic        tag_wr, tag_uwr;
  logic [3:0]  tag_uptr;
  logic [25:0] tag_wdata;
  logic        cache_mem_csb0, cache_mem_web0;
  logic [8:0]  cache_mem_addr0;
  logic [3:0]  cache_mem_wmask0;
  logic [31:0] cache_mem_din0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int uwr_cnt = 0;
  int wr_cnt = 0;

  icache_line_fill_ctrl dut (
    .mclk(mclk), .rst_n(rst_n), .cpu_addr(cpu_addr), .prefill_base(prefill_base),
    .refill_req(refill_req), .prefill_req(prefill_req), .cpu_dat_o(cpu_dat_o),
    .cpu_ack_o(cpu_ack_o), .cache_busy(cache_busy), .fill_err(fill_err),
    .wb_app_stb_o(wb_app_stb_o), .wb_app_we_o(wb_app_we_o), .wb_app_adr_o(wb_app_adr_o),
    .wb_app_sel_o(wb_app_sel_o), .wb_app_bl_o(wb_app_bl_o), .wb_app_dat_i(wb_app_dat_i),
    .wb_app_ack_i(wb_app_ack_i), .wb_app_lack_i(wb_app_lack_i), .wb_app_err_i(wb_app_err_i),
    .tag_cur_loc(tag_cur_loc), .tag_wr(tag_wr), .tag_uwr(tag_uwr), .tag_uptr(tag_uptr),
    .tag_wdata(tag_wdata), .cache_mem_csb0(cache_mem_csb0), .cache_mem_web0(cache_mem_web0),
    .cache_mem_addr0(cache_mem_addr0), .cache_mem_wmask0(cache_mem_wmask0),
    .cache_mem_din0(cache_mem_din0), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    if (tag_uwr === 1'b1) uwr_cnt++;
    if (tag_wr === 1'b1) wr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic bus_idle();
    wb_app_ack_i = 1'b0; wb_app_lack_i = 1'b0; wb_app_err_i = 1'b0;
  endtask

  task automatic start_refill(input logic [31:0] addr, input logic [3:0] loc);
    cpu_addr = addr; tag_cur_loc = loc; refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
  endtask

  task automatic beat(input logic [31:0] dat, input logic last, input logic err);
    wb_app_ack_i = 1'b1; wb_app_lack_i = last; wb_app_err_i = err; wb_app_dat_i = dat;
    tick();
  endtask

  task automatic test_reset();
    checks++; if (cache_busy !== 1'b0 || wb_app_stb_o !== 1'b0 || fill_err !== 1'b0 || cpu_ack_o !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: busy=%b stb=%b err=%b ack=%b, want all 0", cache_busy, wb_app_stb_o, fill_err, cpu_ack_o); end
    checks++; if (cache_mem_csb0 !== 1'b1 || cache_mem_web0 !== 1'b1) begin
      failures++; $display("FAIL reset_mem: csb0=%b web0=%b, want 1 1", cache_mem_csb0, cache_mem_web0); end
    checks++; if (wb_app_adr_o !== 32'h0 || wb_app_bl_o !== 10'd0 || wb_app_sel_o !== 4'h0 || tag_wr !== 1'b0 || tag_uwr !== 1'b0 || tag_wdata !== 26'h0) begin
      failures++; $display("FAIL reset_bus: adr=%h bl=%0d sel=%h twr=%b tuwr=%b twd=%h, want zeros", wb_app_adr_o, wb_app_bl_o, wb_app_sel_o, tag_wr, tag_uwr, tag_wdata); end
    checks++; if (dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_refill();
    start_refill(32'h0000_1A4C, 4'd5);
    checks++; if (cache_busy !== 1'b1 || wb_app_stb_o !== 1'b1 || wb_app_we_o !== 1'b0 || wb_app_sel_o !== 4'hF || wb_app_bl_o !== 10'd32) begin
      failures++; $display("FAIL refill_accept: busy=%b stb=%b we=%b sel=%h bl=%0d", cache_busy, wb_app_stb_o, wb_app_we_o, wb_app_sel_o, wb_app_bl_o); end
    checks++; if (wb_app_adr_o !== 32'h0000_1A00) begin
      failures++; $display("FAIL refill_adr: got %h want 00001a00", wb_app_adr_o); end
    checks++; if (tag_uwr !== 1'b1 || tag_uptr !== 4'd5 || tag_wdata !== 26'h0) begin
      failures++; $display("FAIL refill_uwr: uwr=%b uptr=%0d wdata=%h, want 1 5 0", tag_uwr, tag_uptr, tag_wdata); end
    for (int i = 0; i < 32; i++) begin
      beat(32'hD000_0000 + 32'(i), i == 31, 1'b0);
      checks++; if (cache_mem_csb0 !== 1'b0 || cache_mem_web0 !== 1'b0 || cache_mem_addr0 !== 9'(32'hA0 + i) || cache_mem_din0 !== 32'hD000_0000 + 32'(i)) begin
        failures++; $display("FAIL refill_mem[%0d]: csb0=%b web0=%b addr0=%h din0=%h", i, cache_mem_csb0, cache_mem_web0, cache_mem_addr0, cache_mem_din0); end
      checks++; if (cpu_ack_o !== (i == 19)) begin
        failures++; $display("FAIL refill_cpu_ack[%0d]: got %b want %b", i, cpu_ack_o, i == 19); end
      if (i == 19) begin
        checks++; if (cpu_dat_o !== 32'hD000_0013) begin
          failures++; $display("FAIL refill_cpu_dat: got %h want d0000013", cpu_dat_o); end
      end
    end
    checks++; if (tag_wr !== 1'b1 || tag_uptr !== 4'd5 || tag_wdata !== 26'h200_0034 || wb_app_stb_o !== 1'b0) begin
      failures++; $display("FAIL refill_tag_wr: wr=%b uptr=%0d wdata=%h stb=%b, want 1 5 2000034 0", tag_wr, tag_uptr, tag_wdata, wb_app_stb_o); end
    bus_idle();
    checks++; if (cache_busy !== 1'b1 || dbg_state !== 2'd3) begin
      failures++; $display("FAIL refill_done: busy=%b state=%0d, want 1 3", cache_busy, dbg_state); end
    tick();
    checks++; if (cache_busy !== 1'b0 || tag_wr !== 1'b0 || cache_mem_csb0 !== 1'b1 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL refill_idle: busy=%b twr=%b csb0=%b state=%0d", cache_busy, tag_wr, cache_mem_csb0, dbg_state); end
  endtask

  task automatic test_prefill();
    uwr_cnt = 0; wr_cnt = 0;
    prefill_base = 32'h0000_0800; prefill_req = 1'b1;
    tick();
    prefill_req = 1'b0;
    for (int b = 0; b < 16; b++) begin
      checks++; if (wb_app_adr_o !== 32'h800 + 32'(b) * 32'h80 || wb_app_stb_o !== 1'b1 || tag_uwr !== 1'b1 || tag_uptr !== 4'(b)) begin
        failures++; $display("FAIL prefill_start[%0d]: adr=%h stb=%b uwr=%b uptr=%0d", b, wb_app_adr_o, wb_app_stb_o, tag_uwr, tag_uptr); end
      for (int w = 0; w < 32; w++) begin
        beat(32'(b * 256 + w), w == 31, 1'b0);
        checks++; if (cache_mem_csb0 !== 1'b0 || cache_mem_addr0 !== 9'(b * 32 + w) || cpu_ack_o !== 1'b0) begin
          failures++; $display("FAIL prefill_mem[%0d,%0d]: csb0=%b addr0=%h cpu_ack=%b", b, w, cache_mem_csb0, cache_mem_addr0, cpu_ack_o); end
      end
      checks++; if (tag_wr !== 1'b1 || tag_uptr !== 4'(b) || tag_wdata !== {1'b1, 25'(16 + b)}) begin
        failures++; $display("FAIL prefill_tag[%0d]: wr=%b uptr=%0d wdata=%h", b, tag_wr, tag_uptr, tag_wdata); end
      bus_idle();
      if (b == 15) begin
        checks++; if (cache_busy !== 1'b1) begin
          failures++; $display("FAIL prefill_busy_done: got %b want 1", cache_busy); end
      end
      tick();
    end
    checks++; if (cache_busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL prefill_end: busy=%b state=%0d, want 0 0", cache_busy, dbg_state); end
    checks++; if (uwr_cnt !== 16 || wr_cnt !== 16) begin
      failures++; $display("FAIL prefill_pulses: uwr=%0d wr=%0d, want 16 16", uwr_cnt, wr_cnt); end
  endtask

  task automatic test_err();
    wr_cnt = 0;
    start_refill(32'h0000_1A4C, 4'd5);
    for (int i = 0; i < 4; i++) beat(32'h1111_0000 + 32'(i), 1'b0, 1'b0);
    beat(32'h1111_0004, 1'b0, 1'b1);
    checks++; if (wb_app_stb_o !== 1'b0 || fill_err !== 1'b1 || tag_wr !== 1'b0 || cpu_ack_o !== 1'b0 || cache_mem_csb0 !== 1'b1) begin
      failures++; $display("FAIL err_abort: stb=%b err=%b twr=%b cpu_ack=%b csb0=%b, want 0 1 0 0 1", wb_app_stb_o, fill_err, tag_wr, cpu_ack_o, cache_mem_csb0); end
    bus_idle();
    tick();
    checks++; if (cache_busy !== 1'b0 || fill_err !== 1'b1 || wr_cnt !== 0) begin
      failures++; $display("FAIL err_idle: busy=%b err=%b wr_pulses=%0d, want 0 1 0", cache_busy, fill_err, wr_cnt); end
  endtask

  task automatic test_timeout();
    start_refill(32'h0000_2000, 4'd3);
    checks++; if (fill_err !== 1'b0) begin
      failures++; $display("FAIL timeout_err_clear: got %b want 0", fill_err); end
    for (int i = 0; i < 3; i++) beat(32'h2222_0000 + 32'(i), 1'b0, 1'b0);
    bus_idle();
    repeat (1023) tick();
    checks++; if (wb_app_stb_o !== 1'b1 || fill_err !== 1'b0) begin
      failures++; $display("FAIL timeout_early: stb=%b err=%b, want 1 0", wb_app_stb_o, fill_err); end
    tick();
    checks++; if (wb_app_stb_o !== 1'b0 || fill_err !== 1'b1 || tag_wr !== 1'b0 || dbg_state !== 2'd3) begin
      failures++; $display("FAIL timeout_abort: stb=%b err=%b twr=%b state=%0d, want 0 1 0 3", wb_app_stb_o, fill_err, tag_wr, dbg_state); end
    tick();
    checks++; if (cache_busy !== 1'b0) begin
      failures++; $display("FAIL timeout_idle: busy=%b want 0", cache_busy); end
  endtask

  task automatic test_priority();
    cpu_addr = 32'h0000_3000; tag_cur_loc = 4'd7; prefill_base = 32'h0000_0800;
    refill_req = 1'b1; prefill_req = 1'b1;
    tick();
    checks++; if (wb_app_adr_o !== 32'h0000_3000 || tag_uptr !== 4'd7 || dbg_state !== 2'd1) begin
      failures++; $display("FAIL prio_accept: adr=%h uptr=%0d state=%0d, want 3000 7 1", wb_app_adr_o, tag_uptr, dbg_state); end
    cpu_addr = 32'h0000_5000; tag_cur_loc = 4'd9;
    repeat (3) tick();
    checks++; if (wb_app_adr_o !== 32'h0000_3000 || tag_uptr !== 4'd7 || tag_uwr !== 1'b0) begin
      failures++; $display("FAIL prio_busy_ignore: adr=%h uptr=%0d uwr=%b", wb_app_adr_o, tag_uptr, tag_uwr); end
    refill_req = 1'b0; prefill_req = 1'b0;
    wb_app_err_i = 1'b1;
    tick();
    bus_idle();
    tick();
    tick();
    checks++; if (cache_busy !== 1'b0 || dbg_state !== 2'd0 || wb_app_stb_o !== 1'b0) begin
      failures++; $display("FAIL prio_prefill_dropped: busy=%b state=%0d stb=%b, want 0 0 0", cache_busy, dbg_state, wb_app_stb_o); end
  endtask

  task automatic test_reset_mid_burst();
    start_refill(32'h0000_1A4C, 4'd5);
    wr_cnt = 0;
    for (int i = 0; i < 9; i++) beat(32'h3333_0000 + 32'(i), 1'b0, 1'b0);
    wb_app_ack_i = 1'b1; wb_app_dat_i = 32'h3333_0009;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cache_busy !== 1'b0 || wb_app_stb_o !== 1'b0 || wb_app_adr_o !== 32'h0 || cache_mem_csb0 !== 1'b1 || cache_mem_web0 !== 1'b1 || tag_wr !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL rst_async: busy=%b stb=%b adr=%h csb0=%b web0=%b twr=%b state=%0d", cache_busy, wb_app_stb_o, wb_app_adr_o, cache_mem_csb0, cache_mem_web0, tag_wr, dbg_state); end
    @(negedge mclk);
    bus_idle();
    rst_n = 1'b1;
    tick();
    checks++; if (wr_cnt !== 0 || cache_busy !== 1'b0 || fill_err !== 1'b0) begin
      failures++; $display("FAIL rst_no_tag_wr: wr_pulses=%0d busy=%b err=%b, want 0 0 0", wr_cnt, cache_busy, fill_err); end
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_addr = '0; prefill_base = '0; refill_req = 1'b0; prefill_req = 1'b0;
    wb_app_dat_i = '0; tag_cur_loc = '0;
    bus_idle();
    repeat (3) @(negedge mclk);
    test_reset();
    rst_n = 1'b1;
    tick();
    test_refill();
    test_prefill();
    test_err();
    test_timeout();
    test_priority();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
